// File: rtl/alu_mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers; results commit after a fixed latency.
// Define MDU_MADD_EN to enable madd/maddu (ops 6/7); otherwise those ops are no-ops.
module alu_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUop,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0]   r_temp, w_temp_nxt;
  logic [WIDTH-1:0]     r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [2*WIDTH-1:0]   w_commit;
`ifdef MDU_MADD_EN
  logic                 r_acc, w_acc_nxt;
`endif

  // Full 2*WIDTH product; low bits of the extended product are exact for both signednesses.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic [2*WIDTH-1:0] ea, eb;
    ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed divide works on magnitudes, which also yields
  // lo=rs, hi=0 for most-negative / -1 without a special case.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic [WIDTH-1:0] q, r, ma, mb;
    q  = '0;
    r  = '0;
    ma = (sgn && a[WIDTH-1]) ? -a : a;
    mb = (sgn && b[WIDTH-1]) ? -b : b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) q = -q;
      if (sgn && a[WIDTH-1])                r = -r;
    end
    return {r, q};
  endfunction

`ifdef MDU_MADD_EN
  assign w_commit = r_acc ? ({r_hi, r_lo} + r_temp) : r_temp;
`else
  assign w_commit = r_temp;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_temp_nxt  = r_temp;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
`ifdef MDU_MADD_EN
    w_acc_nxt   = r_acc;
`endif
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_temp_nxt  = '0;
    end else if (r_state == S_RUN) begin
      if (r_cnt == CW'(1)) begin
        {w_hi_nxt, w_lo_nxt} = w_commit;
        w_state_nxt          = S_IDLE;
        w_cnt_nxt            = '0;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end else if (start) begin
`ifdef MDU_MADD_EN
      w_acc_nxt = 1'b0;
`endif
      case (MDUop)
        3'd0: begin w_temp_nxt = mul_full(rs, rt, 1'b1); w_cnt_nxt = MULT_N; w_state_nxt = S_RUN; end
        3'd1: begin w_temp_nxt = mul_full(rs, rt, 1'b0); w_cnt_nxt = MULT_N; w_state_nxt = S_RUN; end
        3'd2: begin w_temp_nxt = div_full(rs, rt, 1'b1); w_cnt_nxt = DIV_N;  w_state_nxt = S_RUN; end
        3'd3: begin w_temp_nxt = div_full(rs, rt, 1'b0); w_cnt_nxt = DIV_N;  w_state_nxt = S_RUN; end
        3'd4: w_hi_nxt = rs;
        3'd5: w_lo_nxt = rs;
`ifdef MDU_MADD_EN
        3'd6: begin
          w_temp_nxt = mul_full(rs, rt, 1'b1); w_acc_nxt = 1'b1;
          w_cnt_nxt  = MULT_N;                 w_state_nxt = S_RUN;
        end
        3'd7: begin
          w_temp_nxt = mul_full(rs, rt, 1'b0); w_acc_nxt = 1'b1;
          w_cnt_nxt  = MULT_N;                 w_state_nxt = S_RUN;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_temp  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MDU_MADD_EN
      r_acc   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_temp  <= w_temp_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
`ifdef MDU_MADD_EN
      r_acc   <= w_acc_nxt;
`endif
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu: latency, mult/div results, mthi/mtlo, flush, reset and madd.
module tb_alu_mdu;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic [2:0]     MDUop = 3'd0;
  logic [W-1:0]   rs = '0;
  logic [W-1:0]   rt = '0;
  logic           busy;
  logic [W-1:0]   hi, lo;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUop(MDUop), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds start for one posedge; returns at the negedge after the issue edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; MDUop = op; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int n, input logic [W-1:0] ehi,
                     input logic [W-1:0] elo);
    int c;
    issue(op, a, b);
    wait_idle(c);
    check({tag, ".cycles"}, 64'(c), 64'(n));
    check({tag, ".hi"}, 64'(hi), 64'(ehi));
    check({tag, ".lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int c;
    #3;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run("mult",  3'd0, 32'hFFFFFFFB, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFF6);
    run("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run("multmin", 3'd0, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
    run("div",   3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divneg", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run("divu0", 3'd3, 32'd7, 32'd0, 10, 32'h00000007, 32'hFFFFFFFF);
    run("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    start = 1'b1; MDUop = 3'd4; rs = 32'h1234;
    @(negedge clk);
    check("mthi.busy", 64'(busy), 64'd0);
    check("mthi.hi", 64'(hi), 64'h1234);
    MDUop = 3'd5; rs = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo.busy", 64'(busy), 64'd0);
    check("mtlo.hi", 64'(hi), 64'h1234);
    check("mtlo.lo", 64'(lo), 64'h5678);

    // starts during RUN are ignored: 100/7 -> q=14, r=2
    issue(3'd2, 32'd100, 32'd7);
    start = 1'b1; MDUop = 3'd0; rs = 32'd3; rt = 32'd3;
    @(negedge clk);
    MDUop = 3'd4; rs = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    check("ign.hi_mid", 64'(hi), 64'h1234);
    check("ign.lo_mid", 64'(lo), 64'h5678);
    wait_idle(c);
    check("ign.cycles", 64'(c), 64'd8);
    check("ign.hi", 64'(hi), 64'd2);
    check("ign.lo", 64'(lo), 64'd14);

    // flush mid-divide
    issue(3'd2, 32'd50, 32'd3);
    repeat (2) @(negedge clk);
    check("flmid.busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flmid.busy", 64'(busy), 64'd0);
    repeat (12) @(negedge clk);
    check("flmid.busy_late", 64'(busy), 64'd0);
    check("flmid.hi", 64'(hi), 64'd2);
    check("flmid.lo", 64'(lo), 64'd14);

    // flush together with start drops the start (mthi and div)
    @(negedge clk);
    start = 1'b1; flush = 1'b1; MDUop = 3'd4; rs = 32'hBEEF;
    @(negedge clk);
    MDUop = 3'd2; rs = 32'd9; rt = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flst.busy", 64'(busy), 64'd0);
    check("flst.hi", 64'(hi), 64'd2);

    // flush on the commit edge suppresses the commit
    issue(3'd0, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    check("flcm.busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flcm.busy", 64'(busy), 64'd0);
    check("flcm.hi", 64'(hi), 64'd2);
    check("flcm.lo", 64'(lo), 64'd14);

    // madd: hi=0, lo=FFFFFFFF, 1*1 accumulated
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'hFFFFFFFF, 32'd0);
    issue(3'd6, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(c);
    check("madd.cycles", 64'(c), 64'd5);
    check("madd.hi", 64'(hi), 64'h1);
    check("madd.lo", 64'(lo), 64'h0);
`else
    check("madd.busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("madd.hi", 64'(hi), 64'h0);
    check("madd.lo", 64'(lo), 64'hFFFFFFFF);
`endif

    // async reset in the middle of a mult
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstrun.busy", 64'(busy), 64'd0);
    check("rstrun.hi", 64'(hi), 64'd0);
    check("rstrun.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("rstrun.busy_after", 64'(busy), 64'd0);
    check("rstrun.hi_after", 64'(hi), 64'd0);
    check("rstrun.lo_after", 64'(lo), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
